// File: rtl/block_merger_pkg.sv
`default_nettype none
// ============================================================================
// Module   : block_merger_pkg
// Purpose  : Shared widths, block-size limit and FSM state codes for the
//            block merger and its upstream block processor.
// Revision : 1.0 - initial release
// ============================================================================
package block_merger_pkg;

    localparam int c_DATA_DEPTH = 8;
    localparam int c_ADDR_WIDTH = 19;
    localparam int c_MAX_M      = 72;

    localparam int c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_CFG        = 3'd1;
    localparam logic [2:0] c_ST_COLLECT    = 3'd2;
    localparam logic [2:0] c_ST_WAIT_DONE  = 3'd3;
    localparam logic [2:0] c_ST_FRAME_DONE = 3'd4;

endpackage
`default_nettype wire

// File: rtl/block_merger_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : block_merger_addr_gen
// Purpose  : Raster address generator for block-ordered pixels; derives
//            W = M*B and Hs = W*M by repeated addition, then walks addresses
//            incrementally.
// Revision : 1.0 - initial release
// ============================================================================
module block_merger_addr_gen
    import block_merger_pkg::*;
#(
    parameter int Data_Depth = c_DATA_DEPTH,
    parameter int Addr_Width = c_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_init,
    input  logic [Data_Depth-1:0] cfg_M,
    input  logic [7:0]            cfg_B,
    input  logic                  cfg_step,
    output logic                  cfg_last,
    input  logic                  frame_clr,
    input  logic                  pix_step,
    output logic                  blk_full,
    input  logic                  blk_step,
    output logic                  frame_last,
    output logic [Addr_Width-1:0] addr
);

    localparam int c_KW = ((Data_Depth > 8) ? Data_Depth : 8) + 1;

    logic [Data_Depth-1:0] r_m;
    logic [7:0]            r_b;
    logic [Addr_Width-1:0] r_w;
    logic [Addr_Width-1:0] r_hs;
    logic [c_KW-1:0]       r_k;
    logic [Data_Depth-1:0] r_c;
    logic [Data_Depth-1:0] r_r;
    logic [7:0]            r_bc;
    logic [7:0]            r_br;
    logic [Addr_Width-1:0] r_row_base;
    logic [Addr_Width-1:0] r_blk_base;
    logic [Addr_Width-1:0] r_addr;

    logic [Data_Depth-1:0] w_m_m1;
    logic [7:0]            w_b_m1;
    logic [Addr_Width-1:0] w_m_ext;
    logic [Addr_Width-1:0] w_row_next;
    logic [Addr_Width-1:0] w_blk_next;
    logic [c_KW-1:0]       w_cfg_last_k;

    assign w_m_m1       = r_m - Data_Depth'(1);
    assign w_b_m1       = r_b - 8'd1;
    assign w_m_ext      = Addr_Width'(r_m);
    assign w_row_next   = r_row_base + r_w;
    assign w_cfg_last_k = c_KW'(r_b) + c_KW'(r_m) - c_KW'(1);

    // Wrapping to the next block row jumps over the M-1 image rows already
    // covered by the current block row: +M then +(Hs - W).
    always_comb begin
        w_blk_next = r_blk_base + w_m_ext;
        if (r_bc == w_b_m1) begin
            w_blk_next = r_blk_base + w_m_ext + r_hs - r_w;
        end
    end

    assign cfg_last   = (r_k == w_cfg_last_k);
    assign blk_full   = (r_c == w_m_m1) && (r_r == w_m_m1);
    assign frame_last = (r_bc == w_b_m1) && (r_br == w_b_m1);
    assign addr       = r_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m        <= '0;
            r_b        <= '0;
            r_w        <= '0;
            r_hs       <= '0;
            r_k        <= '0;
            r_c        <= '0;
            r_r        <= '0;
            r_bc       <= '0;
            r_br       <= '0;
            r_row_base <= '0;
            r_blk_base <= '0;
            r_addr     <= '0;
        end else if (cfg_init) begin
            r_m        <= cfg_M;
            r_b        <= cfg_B;
            r_w        <= '0;
            r_hs       <= '0;
            r_k        <= '0;
            r_c        <= '0;
            r_r        <= '0;
            r_bc       <= '0;
            r_br       <= '0;
            r_row_base <= '0;
            r_blk_base <= '0;
            r_addr     <= '0;
        end else if (cfg_step) begin
            // First B cycles accumulate W, the following M cycles accumulate Hs.
            if (r_k < c_KW'(r_b)) begin
                r_w <= r_w + w_m_ext;
            end else begin
                r_hs <= r_hs + r_w;
            end
            r_k <= r_k + c_KW'(1);
        end else if (frame_clr) begin
            r_c        <= '0;
            r_r        <= '0;
            r_bc       <= '0;
            r_br       <= '0;
            r_row_base <= '0;
            r_blk_base <= '0;
            r_addr     <= '0;
        end else if (pix_step) begin
            if (r_c != w_m_m1) begin
                r_c    <= r_c + Data_Depth'(1);
                r_addr <= r_addr + Addr_Width'(1);
            end else begin
                r_c <= '0;
                if (r_r != w_m_m1) begin
                    r_r        <= r_r + Data_Depth'(1);
                    r_row_base <= w_row_next;
                    r_addr     <= w_row_next;
                end else begin
                    r_r <= '0;
                end
            end
        end else if (blk_step) begin
            if (r_bc != w_b_m1) begin
                r_bc <= r_bc + 8'd1;
            end else begin
                r_bc <= '0;
                r_br <= (r_br == w_b_m1) ? 8'd0 : r_br + 8'd1;
            end
            r_blk_base <= w_blk_next;
            r_row_base <= w_blk_next;
            r_addr     <= w_blk_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/block_merger.sv
`default_nettype none
// ============================================================================
// Module   : block_merger
// Purpose  : Merges per-block pixel results into a raster image memory.
//            Optional protocol checker enabled by BLOCK_MERGER_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module block_merger
    import block_merger_pkg::*;
#(
    parameter int Data_Depth = c_DATA_DEPTH,
    parameter int Addr_Width = c_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  cfg_load,
    input  logic [Data_Depth-1:0] cfg_M,
    input  logic [7:0]            cfg_B,
    input  logic [Data_Depth-1:0] Pixel_Data,
    input  logic                  new_pixel,
    input  logic                  block_done,
    output logic                  wr_en,
    output logic [Addr_Width-1:0] wr_addr,
    output logic [Data_Depth-1:0] wr_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err
);

    state_t                r_state;
    logic                  r_np_q;
    logic                  r_bd_q;
    logic                  r_wr_en;
    logic [Addr_Width-1:0] r_wr_addr;
    logic [Data_Depth-1:0] r_wr_data;

    logic                  w_event;
    logic                  w_bd_rise;
    logic                  w_cfg_acc;
    logic                  w_cfg_step;
    logic                  w_frame_clr;
    logic                  w_pix_step;
    logic                  w_blk_step;
    logic                  w_cfg_last;
    logic                  w_blk_full;
    logic                  w_frame_last;
    logic [Addr_Width-1:0] w_addr;

    assign w_event     = new_pixel ^ r_np_q;
    assign w_bd_rise   = block_done & ~r_bd_q;
    assign w_cfg_acc   = en & cfg_load & (r_state != c_ST_CFG);
    assign w_cfg_step  = en & (r_state == c_ST_CFG);
    assign w_frame_clr = en & ~w_cfg_acc & (r_state == c_ST_FRAME_DONE);
    assign w_pix_step  = en & ~w_cfg_acc & (r_state == c_ST_COLLECT) & w_event;
    assign w_blk_step  = en & ~w_cfg_acc & (r_state == c_ST_WAIT_DONE) & w_bd_rise;

    block_merger_addr_gen #(
        .Data_Depth (Data_Depth),
        .Addr_Width (Addr_Width)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .cfg_init   (w_cfg_acc),
        .cfg_M      (cfg_M),
        .cfg_B      (cfg_B),
        .cfg_step   (w_cfg_step),
        .cfg_last   (w_cfg_last),
        .frame_clr  (w_frame_clr),
        .pix_step   (w_pix_step),
        .blk_full   (w_blk_full),
        .blk_step   (w_blk_step),
        .frame_last (w_frame_last),
        .addr       (w_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_np_q    <= 1'b0;
            r_bd_q    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (en) begin
            r_np_q  <= new_pixel;
            r_bd_q  <= block_done;
            r_wr_en <= 1'b0;
            if (w_cfg_acc) begin
                r_state <= c_ST_CFG;
            end else begin
                case (r_state)
                    c_ST_CFG: begin
                        if (w_cfg_last) begin
                            r_state <= c_ST_COLLECT;
                        end
                    end
                    c_ST_COLLECT: begin
                        if (w_event) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_addr;
                            r_wr_data <= Pixel_Data;
                            if (w_blk_full) begin
                                r_state <= c_ST_WAIT_DONE;
                            end
                        end
                    end
                    c_ST_WAIT_DONE: begin
                        if (w_bd_rise) begin
                            r_state <= w_frame_last ? c_ST_FRAME_DONE : c_ST_COLLECT;
                        end
                    end
                    c_ST_FRAME_DONE: begin
                        r_state <= c_ST_COLLECT;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign busy       = (r_state == c_ST_CFG) || (r_state == c_ST_COLLECT) ||
                        (r_state == c_ST_WAIT_DONE);
    assign frame_done = (r_state == c_ST_FRAME_DONE);

`ifdef BLOCK_MERGER_CHECK_EN
    logic r_err;

    // Flags pixels arriving outside COLLECT and block_done arriving inside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (en) begin
            if (w_cfg_acc) begin
                r_err <= 1'b0;
            end else if ((w_event && (r_state != c_ST_COLLECT)) ||
                         (w_bd_rise && (r_state == c_ST_COLLECT))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_block_merger.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_merger
// Purpose  : Self-checking bench for block_merger: directed scenarios plus
//            randomized frames against a raster-address reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_merger;

    localparam int DD = 8;
    localparam int AW = 19;
`ifdef BLOCK_MERGER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          cfg_load;
    logic [DD-1:0] cfg_M;
    logic [7:0]    cfg_B;
    logic [DD-1:0] Pixel_Data;
    logic          new_pixel;
    logic          block_done;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DD-1:0] wr_data;
    logic          busy;
    logic          frame_done;
    logic          err;

    int n_vec  = 0;
    int n_fail = 0;
    logic [AW+DD-1:0] exp_q[$];
    bit exp_err = 1'b0;
    int m_cfg = 1;
    int b_cfg = 1;

    always #5 clk = ~clk;

    block_merger #(.Data_Depth(DD), .Addr_Width(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_load   (cfg_load),
        .cfg_M      (cfg_M),
        .cfg_B      (cfg_B),
        .Pixel_Data (Pixel_Data),
        .new_pixel  (new_pixel),
        .block_done (block_done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            check("write_expected", 32'(wr_en), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("write_addr_data", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_err();
        check("err", 32'(err), CHK ? 32'(exp_err) : 32'd0);
    endtask

    // Reference raster address of pixel k of block n (block-row major).
    function automatic int exp_addr(input int n, input int k);
        int bx, by, r, c, w;
        bx = n % b_cfg;
        by = n / b_cfg;
        r  = k / m_cfg;
        c  = k % m_cfg;
        w  = m_cfg * b_cfg;
        return ((by * m_cfg + r) * w + bx * m_cfg + c) % (1 << AW);
    endfunction

    task automatic do_cfg(input int m, input int b, input bit probe);
        cfg_M = DD'(m);
        cfg_B = 8'(b);
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        m_cfg = m;
        b_cfg = b;
        exp_err = 1'b0;
        for (int i = 0; i < m + b; i++) begin
            check("cfg_busy", 32'(busy), 32'd1);
            check("cfg_no_write", 32'(wr_en), 32'd0);
            if (probe && (i == m + b - 1)) begin
                new_pixel = ~new_pixel;
                exp_err = 1'b1;
            end
            tick();
        end
        check("cfg_done_busy", 32'(busy), 32'd1);
        check_err();
    endtask

    task automatic send_pixel(input logic [DD-1:0] d, input bit wr, input int addr, input int lo);
        logic [AW-1:0] a;
        a = addr[AW-1:0];
        Pixel_Data = d;
        new_pixel = ~new_pixel;
        if (lo > 0) begin
            en = 1'b0;
            repeat (lo) tick();
            en = 1'b1;
        end
        tick();
        if (wr) exp_q.push_back({a, d});
        check("wr_strobe", 32'(wr_en), 32'(wr));
        tick();
        check("wr_single", 32'(wr_en), 32'd0);
    endtask

    task automatic pulse_bd(input bit last);
        block_done = 1'b1;
        tick();
        check("frame_done", 32'(frame_done), 32'(last));
        check("busy_after_bd", 32'(busy), 32'(!last));
        block_done = 1'b0;
        tick();
        check("frame_done_clr", 32'(frame_done), 32'd0);
        check("busy_collect", 32'(busy), 32'd1);
    endtask

    task automatic run_block(input int n);
        if ($urandom_range(0, 3) == 0) begin
            pulse_bd(1'b0);
            exp_err = 1'b1;
        end
        for (int k = 0; k < m_cfg * m_cfg; k++) begin
            send_pixel(DD'($urandom), 1'b1, exp_addr(n, k),
                       ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        if ($urandom_range(0, 3) == 0) begin
            send_pixel(DD'($urandom), 1'b0, 0, 0);
            exp_err = 1'b1;
        end
        check_err();
        pulse_bd(n == b_cfg * b_cfg - 1);
    endtask

    int tbl [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

    initial begin
        rst = 1'b1; en = 1'b1; cfg_load = 1'b0; cfg_M = '0; cfg_B = '0;
        Pixel_Data = '0; new_pixel = 1'b0; block_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // M=2, B=2: CFG length probed with an event in its final cycle.
        do_cfg(2, 2, 1'b1);
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 4; k++) begin
                send_pixel(DD'(8'h10 + n * 4 + k), 1'b1, tbl[n * 4 + k], 0);
            end
            check("pending_writes", 32'(exp_q.size()), 32'd0);
            pulse_bd(n == 3);
        end

        // en held low for 3 cycles across a pending event.
        send_pixel(8'hA5, 1'b1, 0, 3);
        for (int k = 1; k < 4; k++) send_pixel(DD'(8'h20 + k), 1'b1, exp_addr(0, k), 0);
        // Fifth event before block_done is dropped.
        send_pixel(8'h5A, 1'b0, 0, 0);
        exp_err = 1'b1;
        check_err();
        pulse_bd(1'b0);

        // Reconfiguration mid-block restarts the frame.
        for (int k = 0; k < 3; k++) send_pixel(DD'(8'h30 + k), 1'b1, exp_addr(1, k), 0);
        do_cfg(2, 2, 1'b0);
        for (int k = 0; k < 4; k++) send_pixel(DD'(8'h40 + k), 1'b1, exp_addr(0, k), 0);
        check("pending_writes", 32'(exp_q.size()), 32'd0);

        // Reset while waiting for block_done.
        rst = 1'b1;
        new_pixel = 1'b0;
        tick();
        rst = 1'b0;
        check("rst2_wr_en", 32'(wr_en), 32'd0);
        check("rst2_wr_addr", 32'(wr_addr), 32'd0);
        check("rst2_wr_data", 32'(wr_data), 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_frame_done", 32'(frame_done), 32'd0);
        check("rst2_err", 32'(err), 32'd0);
        block_done = 1'b1;
        tick();
        check("rst2_no_frame_done", 32'(frame_done), 32'd0);
        block_done = 1'b0;
        tick();
        check("rst2_no_frame_done2", 32'(frame_done), 32'd0);
        check("rst2_idle", 32'(busy), 32'd0);

        // Randomized configurations, one or two frames each.
        for (int t = 0; t < 6; t++) begin
            do_cfg(int'($urandom_range(1, 5)), int'($urandom_range(1, 3)), 1'b0);
            for (int f = 0; f < int'($urandom_range(1, 2)); f++) begin
                for (int n = 0; n < b_cfg * b_cfg; n++) run_block(n);
            end
        end

        tick();
        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/block_merger.md
BLOCK_MERGER -- requirements
Module: block_merger

Interface
REQ-001 The parameter Data_Depth SHALL default to 8 and set the pixel width.
REQ-002 The parameter Addr_Width SHALL default to 19 and set the image memory address width (720*720 pixels).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  when low, all state, outputs and the toggle history SHALL hold.
REQ-006 cfg_load  input  1  one-cycle strobe; captures cfg_M and cfg_B.
REQ-007 cfg_M  input  Data_Depth  block side M in pixels, from 1 to 72.
REQ-008 cfg_B  input  8  blocks per image side B; the image is B*B blocks.
REQ-009 Pixel_Data  input  Data_Depth  result pixel from the upstream block processor.
REQ-010 new_pixel  input  1  toggle; each change of level marks one valid Pixel_Data.
REQ-011 block_done  input  1  upstream end-of-block indication.
REQ-012 wr_en  output  1  image memory write strobe, one cycle per pixel.
REQ-013 wr_addr  output  Addr_Width  raster address, row*W + col, where W = M*B.
REQ-014 wr_data  output  Data_Depth  pixel to write.
REQ-015 busy  output  1  high in CFG, COLLECT and WAIT_DONE.
REQ-016 frame_done  output  1  one-cycle pulse after the last block of a frame.
REQ-017 err  output  1  sticky protocol error flag.

Function
REQ-018 States SHALL be IDLE, CFG, COLLECT, WAIT_DONE and FRAME_DONE.
REQ-019 cfg_load SHALL be accepted in every state except CFG, SHALL abort any frame in progress, and SHALL move the block to CFG.
REQ-020 CFG SHALL compute W = M*B by B additions, then Hs = W*M by M additions, taking exactly B+M cycles, then go to COLLECT with all counters zeroed.
REQ-021 A pixel event SHALL be new_pixel differing from its registered copy np_q; np_q SHALL update only while en is high.
REQ-022 On an event in COLLECT, the next edge SHALL assert wr_en for one cycle with wr_data = Pixel_Data and wr_addr = the current address (latency 1 clock).
REQ-023 Address generation SHALL be incremental only (no multipliers), using in-block counters c and r (0..M-1), block counters bc and br (0..B-1), and bases row_base and blk_base.
REQ-024 When c < M-1, the address SHALL advance by 1; otherwise c SHALL clear and r SHALL increment, and the address SHALL become the next row_base (row_base + W).
REQ-025 After the M*M-th pixel of a block, the state SHALL go to WAIT_DONE.
REQ-026 In WAIT_DONE, a rising block_done SHALL advance bc; blk_base SHALL advance by M; the state SHALL return to COLLECT.
REQ-027 When bc wraps, br SHALL increment and blk_base SHALL advance by Hs - W.
REQ-028 When br wraps, the state SHALL go to FRAME_DONE.
REQ-029 FRAME_DONE SHALL pulse frame_done for one cycle and SHALL return to COLLECT for the next frame with counters zeroed and configuration retained.
REQ-030 Events in IDLE, CFG, WAIT_DONE or FRAME_DONE SHALL be dropped with no write.
REQ-031 A block_done rising edge in COLLECT SHALL be ignored.
REQ-032 An event and a rising block_done in the same cycle SHALL follow the current state's rule for each signal independently.
REQ-033 Configurations with M*B*M*B > 2^Addr_Width SHALL be unsupported; address arithmetic SHALL wrap modulo 2^Addr_Width.

Reset
REQ-034 rst SHALL force IDLE and zero wr_en, wr_addr, wr_data, busy, frame_done, err, np_q, all counters, bases, W and Hs.
REQ-035 rst asserted mid-frame SHALL take effect at the next edge regardless of en, with no further writes.

Configuration
REQ-036 When BLOCK_MERGER_CHECK_EN is defined, err SHALL set on any dropped event (REQ-030) and on any ignored block_done (REQ-031), and SHALL clear only on rst or cfg_load.
REQ-037 When BLOCK_MERGER_CHECK_EN is undefined, err SHALL be tied to 0 and no check logic SHALL be synthesised.

Structure
REQ-038 A shared package SHALL hold the state enumeration, the Data_Depth and Addr_Width defaults, and the maximum M (72) shared with the upstream block processor.
REQ-039 One sub-module, block_merger_addr_gen, SHALL hold the counters, bases and address arithmetic; the top level SHALL hold the FSM, toggle detection and error logic.

Verification
REQ-040 cfg_M=2, cfg_B=2 -> busy high and no writes for 4 cycles; W=4, Hs=8.
REQ-041 Four blocks of 4 pixels each, with block_done between blocks -> write addresses 0,1,4,5 / 2,3,6,7 / 8,9,12,13 / 10,11,14,15, then one frame_done pulse.
REQ-042 Event with Pixel_Data=0xA5 while en is low for 3 cycles -> a single write of 0xA5 one cycle after en rises.
REQ-043 Fifth event before block_done (M=2) -> no write; err=1 with BLOCK_MERGER_CHECK_EN defined, err=0 without it.
REQ-044 cfg_load after 3 pixels of block 1 -> busy stays high and the next pixel after CFG is written at address 0.
REQ-045 rst asserted during WAIT_DONE -> all outputs 0 next cycle; a subsequent block_done produces no frame_done.
